// File: rtl/mul_share_arb_pkg.sv
// Shared types and constants for the shared-multiplier arbiter.
// Optional signed mode is enabled by defining MUL_SHARE_ARB_SIGNED_EN.
package mul_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_e;

    localparam int DEF_N       = 16;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_MUL_LAT = 2;

    // Index width that never collapses to zero bits.
    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mul_share_arb_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant.
// Used by mul_share_arb (MUL_SHARE_ARB_SIGNED_EN has no effect here).
module rr_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDW     = idw(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic [IDW-1:0]     grant,
    output logic               any_grant
);

    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        any_grant = |req;
        found     = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// One multicycle multiplier shared round-robin by NUM_REQ requesters.
// Define MUL_SHARE_ARB_SIGNED_EN to add per-request signed operands.
module mul_share_arb
    import mul_arb_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int MUL_LAT = DEF_MUL_LAT,
    localparam int IDW    = idw(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_a,
    input  logic [NUM_REQ*N-1:0] req_b,
`ifdef MUL_SHARE_ARB_SIGNED_EN
    input  logic [NUM_REQ-1:0]   req_signed,
`endif
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [2*N-1:0]       rsp_data,
    output logic                 busy
);

    localparam int LCW = idw(MUL_LAT);

    state_e         state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] id_q, id_d;
    logic [N-1:0]   op_a_q, op_a_d;
    logic [N-1:0]   op_b_q, op_b_d;
    logic [LCW-1:0] lat_q, lat_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [2*N-1:0] rsp_data_q, rsp_data_d;
`ifdef MUL_SHARE_ARB_SIGNED_EN
    logic           sgn_q, sgn_d;
`endif

    logic [IDW-1:0] grant;
    logic           any_grant;
    logic [2*N-1:0] ext_a, ext_b, product;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_q),
        .grant      (grant),
        .any_grant  (any_grant)
    );

    // Signed mode sign-extends to 2N bits; the low 2N product bits
    // are then the correct two's complement result.
    always_comb begin
        ext_a = {{N{1'b0}}, op_a_q};
        ext_b = {{N{1'b0}}, op_b_q};
`ifdef MUL_SHARE_ARB_SIGNED_EN
        if (sgn_q) begin
            ext_a = {{N{op_a_q[N-1]}}, op_a_q};
            ext_b = {{N{op_b_q[N-1]}}, op_b_q};
        end
`endif
        product = ext_a * ext_b;
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        lat_d       = lat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
`ifdef MUL_SHARE_ARB_SIGNED_EN
        sgn_d       = sgn_q;
`endif
        req_ready   = '0;
        unique case (state_q)
            IDLE: begin
                if (any_grant) begin
                    req_ready[grant] = 1'b1;
                    op_a_d  = req_a[int'(grant)*N +: N];
                    op_b_d  = req_b[int'(grant)*N +: N];
`ifdef MUL_SHARE_ARB_SIGNED_EN
                    sgn_d   = req_signed[grant];
`endif
                    id_d    = grant;
                    last_d  = grant;
                    lat_d   = LCW'(MUL_LAT - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                if (lat_q == '0) begin
                    rsp_data_d  = product;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= IDW'(NUM_REQ - 1);
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            lat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
`ifdef MUL_SHARE_ARB_SIGNED_EN
            sgn_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            lat_q       <= lat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
`ifdef MUL_SHARE_ARB_SIGNED_EN
            sgn_q       <= sgn_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Shares one N-bit unsigned multiplier between NUM_REQ requesters inside the CPU execute stage.
- Per-requester valid/ready request ports; round-robin arbitration; single response bus tagged with requester ID.
- The multiplier is treated as a multicycle path of MUL_LAT cycles. This block sequences operand capture, wait, and result hold/handshake.

Parameters:
- N, 16, operand width; product is 2*N bits.
- NUM_REQ, 4, number of requesters (>=2).
- MUL_LAT, 2, cycles allowed for the product to settle (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- req_a  input  NUM_REQ*N  packed operand A; slice i belongs to requester i.
- req_b  input  NUM_REQ*N  packed operand B; slice i belongs to requester i.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  IDW  requester index of result; IDW = max(1, clog2(NUM_REQ)).
- rsp_data  output  2*N  product.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE; last_grant = NUM_REQ-1, so requester 0 wins first; rsp_valid=0; rsp_id=0; rsp_data=0; operand registers=0; lat_cnt=0; busy=0.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - grant = first i with req_valid[i], searching last_grant+1, last_grant+2, ... mod NUM_REQ.
  - req_ready[grant]=1 only if some req_valid is set; all other req_ready=0.
  - req_ready is 0 in every other state.
  - On handshake: capture req_a/req_b slice and grant into op_a, op_b, id_q; set last_grant=grant; lat_cnt=MUL_LAT-1; go to CALC.
- CALC:
  - Product is formed combinationally from op_a * op_b, unsigned, full 2*N bits, no truncation.
  - If lat_cnt==0: load rsp_data <= product, rsp_id <= id_q, rsp_valid <= 1, go to RESP.
  - Otherwise lat_cnt decrements.
  - Timing: handshake at edge T gives rsp_valid high after edge T+MUL_LAT.
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_ready=1.
  - On rsp_valid && rsp_ready: rsp_valid <= 0, go to IDLE. rsp_data and rsp_id keep their last value.
  - No new request is accepted in the same cycle as the response handshake.
  - Minimum issue interval is MUL_LAT+2 cycles.
- Fairness: a requester holding req_valid is granted within NUM_REQ-1 other operations. A requester that drops valid before being granted loses nothing.
- Operand inputs are sampled only on the handshake edge; later changes do not affect the in-flight result.
- Reset mid-operation: the in-flight operation is discarded, all outputs return to reset values on the next edge, and no response is produced.
- Width corner: 0xFFFF*0xFFFF = 0xFFFE0001 with N=16; no overflow is possible.

Optional Feature:
- Macro: MUL_SHARE_ARB_SIGNED_EN.
- When defined:
  - Adds input req_signed[NUM_REQ], captured with the operands.
  - If the captured bit is 1, operands are two's complement and the product is the signed 2*N-bit result.
  - Timing and handshake are unchanged.
- When undefined: the port is absent and all products are unsigned.

Decomposition:
- Package mul_arb_pkg holds:
  - the state enum (IDLE, CALC, RESP);
  - an IDW width function;
  - default parameter constants.
- One natural sub-module: rr_arbiter.
  - Parameter NUM_REQ.
  - Inputs: req vector, last_grant index.
  - Outputs: grant index, any_grant.
  - Purely combinational.
- The FSM, counter and result registers stay in mul_share_arb.

Test Plan:
- Reset then single request: req 2 valid, a=3, b=5 -> req_ready[2]=1; rsp_valid high MUL_LAT cycles after the handshake; rsp_id=2; rsp_data=15.
- All four valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0; each response carries the matching ID; gap between grants is exactly MUL_LAT+2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_id and rsp_data stay constant, req_ready stays all 0; release -> IDLE on the next edge.
- Max operands: a=0xFFFF, b=0xFFFF -> rsp_data=0xFFFE0001. With the macro defined and req_signed=1, a=0xFFFF (-1), b=0x0002 -> rsp_data=0xFFFFFFFE.
- Reset asserted during CALC -> next edge: busy=0, rsp_valid=0; no response ever appears for the discarded operation; next grant goes to requester 0.
- Operand change after handshake: a=7, b=6 accepted, then the inputs change to a=1, b=1 during CALC -> rsp_data=42.
